// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core (master, holds request until ack) and the responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic        store_byte;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (output req, we, store_byte, addr, wd, input ack, rdata, busy, err);
  modport slave  (input req, we, store_byte, addr, wd, output ack, rdata, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: ack after LATENCY+1 cycles (word) or LATENCY+2 (byte RMW); one request at a time.
// Define DMEM_RESP_ERR_EN to drop out-of-range accesses and flag err; otherwise the word index wraps.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, MERGE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        sb_q, sb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic        oor;
  logic        mem_we;
  logic [31:0] mem_wdat;

  assign idx     = addr_q[AW+1:2];
  assign rd_word = mem[idx];

`ifdef DMEM_RESP_ERR_EN
  assign oor = (addr_q[31:2] >= 30'(DEPTH));
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = ^addr_q[31:AW+2];
`endif

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    merged = merge_q;
    case (addr_q[1:0])
      2'd0:    merged[31:24] = wd_q[7:0];
      2'd1:    merged[23:16] = wd_q[7:0];
      2'd2:    merged[15:8]  = wd_q[7:0];
      default: merged[7:0]   = wd_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    sb_d     = sb_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    mem_wdat = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          sb_d    = bus.we & bus.store_byte;
          addr_d  = bus.addr;
          wd_d    = bus.wd;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = oor ? 32'h0 : rd_word;
            state_d = DONE;
          end else if (sb_q) begin
            merge_d = rd_word;
            state_d = MERGE;
          end else begin
            mem_we  = ~oor;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MERGE: begin
        mem_we   = ~oor;
        mem_wdat = merged;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d == DONE);
    err_d  = ack_d & oor;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sb_q    <= 1'b0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sb_q    <= sb_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM is not reset; an async reset forces state_q to IDLE, which kills any pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= mem_wdat;
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 responder (main) plus a LATENCY=1 responder for the short-latency case.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  int   nchecks = 0;
  int   nerr = 0;

`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut  (.clk(clk), .reset(reset), .bus(bus0.slave));
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.req = r; bus0.we = w; bus0.store_byte = s; bus0.addr = a; bus0.wd = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.store_byte = s; bus1.addr = a; bus1.wd = d;
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? bus0.ack : bus1.ack;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic err_of(input int sel);
    return (sel == 0) ? bus0.err : bus1.err;
  endfunction
  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // exp_lat counts cycles from the capture cycle to the ack cycle.
  task automatic do_req(input int sel, input bit w, input bit s, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input bit chk_rd,
                        input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int n;
    bit got;
    @(negedge clk);
    drive(sel, 1'b1, w, s, a, d);
    @(posedge clk); #1;
    chk({tag, "_busy_cap"}, 32'(busy_of(sel)), 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack_of(sel)) got = 1'b1;
      else chk({tag, "_busy_wait"}, 32'(busy_of(sel)), 32'd1);
    end
    chk({tag, "_lat"}, got ? 32'(n + 1) : 32'd0, 32'(exp_lat));
    if (got) begin
      chk({tag, "_busy_ack"}, 32'(busy_of(sel)), 32'd1);
      chk({tag, "_err"}, 32'(err_of(sel)), 32'(exp_err));
      if (chk_rd) chk({tag, "_rdata"}, rdata_of(sel), exp_rd);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 32'(ack_of(sel)), 32'd0);
    chk({tag, "_idle"}, 32'(busy_of(sel)), 32'd0);
  endtask

  initial begin
    int n;
    int acks;
    logic [31:0] exp_b2b [3];
    exp_b2b[0] = 32'hA1A1A1A1;
    exp_b2b[1] = 32'hB2B2B2B2;
    exp_b2b[2] = 32'hC3C3C3C3;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rst_ack",   32'(bus0.ack),  32'd0);
    chk("rst_rdata", bus0.rdata,     32'h0);
    chk("rst_busy",  32'(bus0.busy), 32'd0);
    chk("rst_err",   32'(bus0.err),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during WAIT aborts the store.
    do_req(0, 1, 0, 32'h10, 32'hCAFEF00D, 3, 0, 32'h0, 0, "pre_sw");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy",  32'(bus0.busy), 32'd0);
    chk("midrst_ack",   32'(bus0.ack),  32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_noack", 32'(bus0.ack), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 0, 0, 32'h10, 32'h0, 3, 1, 32'hCAFEF00D, 0, "midrst_lw");

    // Word round trip.
    do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, 3, 1, 32'hCAFEF00D, 0, "rt_sw");
    do_req(0, 0, 0, 32'h10, 32'h0, 3, 1, 32'hDEADBEEF, 0, "rt_lw");

    // Byte merge on lanes 1, 0, 3; stores leave rdata alone.
    do_req(0, 1, 0, 32'h40, 32'h11223344, 3, 1, 32'hDEADBEEF, 0, "sb1_base");
    do_req(0, 1, 1, 32'h41, 32'h000000AB, 4, 1, 32'hDEADBEEF, 0, "sb1");
    do_req(0, 0, 0, 32'h40, 32'h0, 3, 1, 32'h11AB3344, 0, "sb1_lw");
    do_req(0, 1, 0, 32'h40, 32'h11223344, 3, 1, 32'h11AB3344, 0, "sb0_base");
    do_req(0, 1, 1, 32'h40, 32'h000000AB, 4, 0, 32'h0, 0, "sb0");
    do_req(0, 0, 0, 32'h40, 32'h0, 3, 1, 32'hAB223344, 0, "sb0_lw");
    do_req(0, 1, 0, 32'h40, 32'h11223344, 3, 0, 32'h0, 0, "sb3_base");
    do_req(0, 1, 1, 32'h43, 32'hFFFFFFAB, 4, 0, 32'h0, 0, "sb3");
    do_req(0, 0, 0, 32'h40, 32'h0, 3, 1, 32'h112233AB, 0, "sb3_lw");

    // Back-to-back loads with req held high.
    do_req(0, 1, 0, 32'h04, exp_b2b[0], 3, 0, 32'h0, 0, "b2b_pre0");
    do_req(0, 1, 0, 32'h08, exp_b2b[1], 3, 0, 32'h0, 0, "b2b_pre1");
    do_req(0, 1, 0, 32'h0C, exp_b2b[2], 3, 0, 32'h0, 0, "b2b_pre2");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    @(posedge clk); #1;
    chk("b2b_cap0", 32'(bus0.busy), 32'd1);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!bus0.ack && n < 20);
      if (bus0.ack) acks++;
      chk("b2b_lat", 32'(n), 32'd2);
      chk("b2b_rdata", bus0.rdata, exp_b2b[i]);
      if (i < 2) drive(0, 1'b1, 1'b0, 1'b0, 32'(32'h08 + 4 * i), 32'h0);
      else drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("b2b_pulse", 32'(bus0.ack), 32'd0);
      chk("b2b_idle", 32'(bus0.busy), 32'd0);
      if (i < 2) begin
        @(posedge clk); #1;
        chk("b2b_cap", 32'(bus0.busy), 32'd1);
      end
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (bus0.ack) acks++;
    end
    chk("b2b_acks", 32'(acks), 32'd3);

    // Out-of-range index 64.
    do_req(0, 1, 0, 32'h0, 32'h01020304, 3, 0, 32'h0, 0, "oor_pre");
    do_req(0, 1, 0, 32'h100, 32'h00000055, 3, 0, 32'h0, ERR_EN, "oor_sw");
    do_req(0, 0, 0, 32'h0, 32'h0, 3, 1, ERR_EN ? 32'h01020304 : 32'h00000055, 0, "oor_w0");
    do_req(0, 0, 0, 32'h100, 32'h0, 3, 1, ERR_EN ? 32'h0 : 32'h00000055, ERR_EN, "oor_lw");

    // LATENCY=1, misaligned word store.
    do_req(1, 1, 0, 32'h23, 32'h12345678, 2, 1, 32'h0, 0, "l1_sw");
    do_req(1, 0, 0, 32'h20, 32'h0, 2, 1, 32'h12345678, 0, "l1_lw");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
